// File: rtl/uart_cmd_framer_if.sv
// Byte-strobe input, frame handshake, payload read port and error pulses of the command framer.
// The framer side uses the slave modport; the consumer / UART side uses master.
interface uart_cmd_framer_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Cmd_Valid;
  logic       i_Cmd_Ready;
  logic [7:0] o_Cmd;
  logic [7:0] o_Len;
  logic [7:0] i_Rd_Addr;
  logic [7:0] o_Rd_Data;
  logic       o_Err_Chk;
  logic       o_Err_Len;
  logic       o_Err_Timeout;
  logic       o_Err_Overrun;

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Cmd_Ready, i_Rd_Addr,
    output o_Cmd_Valid, o_Cmd, o_Len, o_Rd_Data,
    output o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Err_Overrun
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Cmd_Ready, i_Rd_Addr,
    input  o_Cmd_Valid, o_Cmd, o_Len, o_Rd_Data,
    input  o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Err_Overrun
  );
endinterface

// File: rtl/uart_cmd_framer.sv
// Frames UART byte strobes into SOF/CMD/LEN/payload/CHK commands with length, checksum
// and inter-byte timeout checks; the pending frame is held until the consumer takes it.
//
// state  | meaning
// S_HUNT | waiting for SOF_BYTE, other bytes ignored
// S_CMD  | expecting command byte
// S_LEN  | expecting length byte
// S_PAY  | collecting payload bytes into the buffer
// S_CHK  | expecting checksum byte
// S_HOLD | good frame pending, o_Cmd_Valid high
module uart_cmd_framer #(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          TIMEOUT_BITS = 40,
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SOF_BYTE     = 8'hA5
) (
  input  logic i_Clock,
  input  logic i_Reset_N,
  uart_cmd_framer_if.slave bus
);

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [31:0] TMO_LAST  = 32'(CLKS_PER_BIT * TIMEOUT_BITS - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_PAY, S_CHK, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic        valid_q, valid_d;
  logic        err_chk_q, err_chk_d;
  logic        err_len_q, err_len_d;
  logic        err_tmo_q, err_tmo_d;
  logic        err_ovr_q, err_ovr_d;
  logic        wr_en;
  logic        in_frame;
  logic [7:0]  buf_q [MAX_LEN];
  logic [7:0]  rd_data_q;

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q   <= S_HUNT;
      cmd_q     <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      valid_q   <= valid_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    tmo_d     = '0;
    wr_en     = 1'b0;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;
    in_frame  = (state_q == S_CMD) || (state_q == S_LEN) ||
                (state_q == S_PAY) || (state_q == S_CHK);

    case (state_q)
      S_HUNT: begin
        if (bus.i_Rx_DV && bus.i_Rx_Byte == SOF_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (bus.i_Rx_DV) begin
          cmd_d   = bus.i_Rx_Byte;
          chk_d   = bus.i_Rx_Byte;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (bus.i_Rx_DV) begin
          if (bus.i_Rx_Byte > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_HUNT;
          end else begin
            len_d   = bus.i_Rx_Byte;
            chk_d   = chk_q ^ bus.i_Rx_Byte;
            idx_d   = '0;
            state_d = (bus.i_Rx_Byte == 8'd0) ? S_CHK : S_PAY;
          end
        end
      end
      S_PAY: begin
        if (bus.i_Rx_DV) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ bus.i_Rx_Byte;
          idx_d = idx_q + 8'd1;
          if (idx_q + 8'd1 == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (bus.i_Rx_DV) begin
          if (bus.i_Rx_Byte == chk_q) begin
            state_d = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_HUNT;
          end
        end
      end
      S_HOLD: begin
        if (bus.i_Rx_DV) err_ovr_d = 1'b1;
        if (valid_q && bus.i_Cmd_Ready) state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase

    // A byte landing on the terminal count takes priority over the timeout.
    if (!bus.i_Rx_DV && in_frame) begin
      if (tmo_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = S_HUNT;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end

    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) buf_q[idx_q[AW-1:0]] <= bus.i_Rx_Byte;
      if (bus.i_Rd_Addr < MAX_LEN_B) rd_data_q <= buf_q[bus.i_Rd_Addr[AW-1:0]];
      else                           rd_data_q <= '0;
    end
  end

  assign bus.o_Cmd_Valid   = valid_q;
  assign bus.o_Cmd         = cmd_q;
  assign bus.o_Len         = len_q;
  assign bus.o_Rd_Data     = rd_data_q;
  assign bus.o_Err_Chk     = err_chk_q;
  assign bus.o_Err_Len     = err_len_q;
  assign bus.o_Err_Timeout = err_tmo_q;
  assign bus.o_Err_Overrun = err_ovr_q;

endmodule

// File: doc/uart_cmd_framer.md
Name: uart_cmd_framer

Overview:
- Sequences the UART receiver's byte strobes into framed commands for the min-OS command layer.
- Frame format: SOF, CMD, LEN, LEN payload bytes, CHK.
- Hunts for frame start, validates length and checksum, enforces an inter-byte timeout, and buffers the payload.
- Presents each completed frame through a valid/ready handshake. The payload is readable by address.

Parameters:
- CLKS_PER_BIT, 104, receiver bit period in i_Clock cycles; sizes the timeout.
- TIMEOUT_BITS, 40, inter-byte timeout in bit periods. Timeout = CLKS_PER_BIT*TIMEOUT_BITS cycles.
- MAX_LEN, 16, maximum payload bytes; must be 1..255.
- SOF_BYTE, 8'hA5, start-of-frame marker.

Ports:
- i_Clock  in  1  system clock
- i_Reset_N  in  1  asynchronous active-low reset
- i_Rx_DV  in  1  one-cycle byte-valid strobe from UART receiver
- i_Rx_Byte  in  8  received byte, valid when i_Rx_DV=1
- o_Cmd_Valid  out  1  completed good frame pending
- i_Cmd_Ready  in  1  consumer accepts frame when high with o_Cmd_Valid
- o_Cmd  out  8  command byte of pending frame
- o_Len  out  8  payload length of pending frame
- i_Rd_Addr  in  8  payload buffer read address
- o_Rd_Data  out  8  payload byte at i_Rd_Addr, registered, 1-cycle latency
- o_Err_Chk  out  1  one-cycle pulse: checksum mismatch
- o_Err_Len  out  1  one-cycle pulse: LEN > MAX_LEN
- o_Err_Timeout  out  1  one-cycle pulse: inter-byte timeout mid-frame
- o_Err_Overrun  out  1  one-cycle pulse: byte arrived while frame pending

Behaviour:
- Reset: the reset is asynchronous and active-low and forces all outputs and state to 0. The state goes to S_HUNT. Reset mid-frame or while holding discards everything.
- Running checksum: CHK = XOR of CMD, LEN and all payload bytes, 8-bit.
- S_HUNT:
  - On i_Rx_DV with byte == SOF_BYTE: go to S_CMD.
  - Any other byte: ignore it and stay in S_HUNT, with no error.
- S_CMD:
  - On i_Rx_DV: latch the command and set chk = byte; go to S_LEN.
- S_LEN:
  - On i_Rx_DV with byte > MAX_LEN: pulse o_Err_Len and go to S_HUNT.
  - On i_Rx_DV with byte == 0: latch the length, chk ^= byte, go to S_CHK.
  - Otherwise: latch the length, chk ^= byte, reset the index to 0, go to S_PAY.
- S_PAY:
  - On each i_Rx_DV: write buf[idx] = byte, chk ^= byte, idx += 1.
  - When idx reaches len (on the write of byte len-1): go to S_CHK.
- S_CHK:
  - On i_Rx_DV with byte == chk: go to S_HOLD and assert o_Cmd_Valid on the next cycle.
  - On mismatch: pulse o_Err_Chk and go to S_HUNT.
- S_HOLD:
  - o_Cmd_Valid stays high. o_Cmd and o_Len stay stable.
  - On o_Cmd_Valid & i_Cmd_Ready: deassert o_Cmd_Valid next cycle and return to S_HUNT.
  - Any i_Rx_DV while in S_HOLD: drop the byte and pulse o_Err_Overrun. The frame is not disturbed.
  - i_Cmd_Ready while o_Cmd_Valid is low has no effect.
- Timeout:
  - The counter clears on every i_Rx_DV and counts only in S_CMD, S_LEN, S_PAY and S_CHK.
  - On reaching CLKS_PER_BIT*TIMEOUT_BITS-1: pulse o_Err_Timeout and go to S_HUNT.
  - The counter is 32 bits wide.
  - If i_Rx_DV and the terminal count occur in the same cycle, the byte wins: no timeout, and the byte is processed.
- SOF_BYTE inside CMD, LEN, payload or CHK is treated as data, with no resync.
- Payload buffer:
  - MAX_LEN x 8 registers or RAM, written only in S_PAY.
  - Read port: o_Rd_Data <= buf[i_Rd_Addr] on each clock.
  - i_Rd_Addr >= MAX_LEN returns 0.
  - Contents are valid while o_Cmd_Valid is high. They are guaranteed stable only in S_HOLD.
- Error pulses are exactly one cycle wide and mutually exclusive per byte.

Test Plan:
- Good frame: send A5 10 03 01 02 03 CHK=0x13 -> o_Cmd_Valid=1 with o_Cmd=0x10 and o_Len=3. Addresses 0,1,2 read 01,02,03 one cycle after the address is applied. Ready pulse -> valid drops next cycle.
- Zero-length and garbage: send 00 FF A5 22 00 22 -> leading bytes ignored, frame accepted with o_Cmd=0x22, o_Len=0, no error pulses.
- Bad checksum: send A5 10 01 55 00 -> o_Err_Chk single pulse, no o_Cmd_Valid. A following good frame is accepted normally.
- Length over MAX_LEN: send A5 10 11 (with MAX_LEN=16) -> o_Err_Len pulse and back to hunt; trailing bytes ignored until the next A5.
- Timeout: send A5 10, then idle for CLKS_PER_BIT*TIMEOUT_BITS cycles -> exactly one o_Err_Timeout pulse. Also check the byte-at-terminal-count case: no timeout fires.
- Overrun and reset: hold a good frame with ready low and send 2 bytes -> two o_Err_Overrun pulses, frame contents unchanged. Assert i_Reset_N=0 mid-payload -> all outputs 0 immediately, and the next good frame is accepted.
